// File: rtl/alu_issue_stage_if.sv
// Signal bundle of the ALU issue stage: instruction handshake, register file reads,
// ALU operand/control drive, ALU result return and register file writeback.
interface alu_issue_stage_if;
    logic [0:31] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        stall_in;
    logic [0:4]  rf_addr_a;
    logic [0:4]  rf_addr_b;
    logic [0:63] rf_data_a;
    logic [0:63] rf_data_b;
    logic [0:63] alu_rA;
    logic [0:63] alu_rB;
    logic [0:5]  alu_Op_code;
    logic [0:5]  alu_R_ins;
    logic [0:1]  alu_WW;
    logic [0:63] alu_result;
    logic        wb_en;
    logic [0:4]  wb_addr;
    logic [0:63] wb_data;

    modport slave (
        input  instr_in, instr_valid, stall_in, rf_data_a, rf_data_b, alu_result,
        output instr_ready, rf_addr_a, rf_addr_b, alu_rA, alu_rB, alu_Op_code,
               alu_R_ins, alu_WW, wb_en, wb_addr, wb_data
    );

    modport master (
        output instr_in, instr_valid, stall_in, rf_data_a, rf_data_b, alu_result,
        input  instr_ready, rf_addr_a, rf_addr_b, alu_rA, alu_rB, alu_Op_code,
               alu_R_ins, alu_WW, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX/WB issue stage for a vector ALU; ALU_ISSUE_FWD_EN forwards alu_result instead of stalling on EX hazards.
// Acceptance to wb_en is 2 cycles; stall_in freezes EX/WB, an EX hazard without forwarding drops instr_ready for one cycle.
module alu_issue_stage (
    input  logic             clk,
    input  logic             reset,
    alu_issue_stage_if.slave bus
);
    localparam logic [0:5] OP_R_ALU = 6'b101010;

    logic [0:63] alu_ra_q, alu_ra_d, alu_rb_q, alu_rb_d;
    logic [0:5]  op_q, op_d, rins_q, rins_d;
    logic [0:1]  ww_q, ww_d;
    logic [0:4]  ex_rd_q, ex_rd_d;
    logic        ex_v_q, ex_v_d;
    logic        wb_en_q, wb_en_d;
    logic [0:4]  wb_addr_q, wb_addr_d;
    logic [0:63] wb_data_q, wb_data_d;

    logic [0:5]  id_op, id_rins;
    logic [0:4]  id_rd, id_ra, id_rb;
    logic [0:1]  id_ww;
    logic        ex_writes, haz_a, haz_b, hazard_stall, accept;
    logic [0:63] opnd_a, opnd_b;
    logic        unused_pad;

    assign id_op      = bus.instr_in[0:5];
    assign id_rd      = bus.instr_in[6:10];
    assign id_ra      = bus.instr_in[11:15];
    assign id_rb      = bus.instr_in[16:20];
    assign id_ww      = bus.instr_in[24:25];
    assign id_rins    = bus.instr_in[26:31];
    assign unused_pad = ^bus.instr_in[21:23];

    assign bus.rf_addr_a = id_ra;
    assign bus.rf_addr_b = id_rb;

    // Only an R_ALU with a real R_ins in EX will ever write back.
    assign ex_writes = ex_v_q && (op_q == OP_R_ALU) && (rins_q != 6'b000000);
    assign haz_a     = ex_writes && (ex_rd_q == id_ra);
    assign haz_b     = ex_writes && (ex_rd_q == id_rb);

`ifdef ALU_ISSUE_FWD_EN
    assign hazard_stall = 1'b0;
`else
    assign hazard_stall = haz_a || haz_b;
`endif

    assign bus.instr_ready = !bus.stall_in && !hazard_stall;
    assign accept          = bus.instr_valid && bus.instr_ready;

    // Youngest producer wins: EX (when forwarding) over WB over the register file.
    always_comb begin
        opnd_a = bus.rf_data_a;
        opnd_b = bus.rf_data_b;
        if (wb_en_q && (wb_addr_q == id_ra)) opnd_a = wb_data_q;
        if (wb_en_q && (wb_addr_q == id_rb)) opnd_b = wb_data_q;
`ifdef ALU_ISSUE_FWD_EN
        if (haz_a) opnd_a = bus.alu_result;
        if (haz_b) opnd_b = bus.alu_result;
`endif
    end

    always_comb begin
        ex_v_d    = ex_v_q;
        ex_rd_d   = ex_rd_q;
        op_d      = op_q;
        rins_d    = rins_q;
        ww_d      = ww_q;
        alu_ra_d  = alu_ra_q;
        alu_rb_d  = alu_rb_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (!bus.stall_in) begin
            wb_en_d   = ex_writes;
            wb_addr_d = ex_rd_q;
            wb_data_d = bus.alu_result;
            if (accept) begin
                ex_v_d   = 1'b1;
                ex_rd_d  = id_rd;
                op_d     = id_op;
                rins_d   = id_rins;
                ww_d     = id_ww;
                alu_ra_d = opnd_a;
                alu_rb_d = opnd_b;
            end else begin
                ex_v_d   = 1'b0;
                ex_rd_d  = '0;
                op_d     = '0;
                rins_d   = '0;
                ww_d     = '0;
                alu_ra_d = '0;
                alu_rb_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_v_q    <= 1'b0;
            ex_rd_q   <= '0;
            op_q      <= '0;
            rins_q    <= '0;
            ww_q      <= '0;
            alu_ra_q  <= '0;
            alu_rb_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            ex_v_q    <= ex_v_d;
            ex_rd_q   <= ex_rd_d;
            op_q      <= op_d;
            rins_q    <= rins_d;
            ww_q      <= ww_d;
            alu_ra_q  <= alu_ra_d;
            alu_rb_q  <= alu_rb_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign bus.alu_rA      = alu_ra_q;
    assign bus.alu_rB      = alu_rb_q;
    assign bus.alu_Op_code = op_q;
    assign bus.alu_R_ins   = rins_q;
    assign bus.alu_WW      = ww_q;
    assign bus.wb_en       = wb_en_q;
    assign bus.wb_addr     = wb_addr_q;
    assign bus.wb_data     = wb_data_q;
endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-003 SHALL have port instr_in, input, [0:31]: instruction word. Fields: opcode [0:5], rD [6:10], rA [11:15], rB [16:20], WW [24:25], R_ins [26:31].
REQ-004 SHALL have port instr_valid, input, 1: instr_in is valid this cycle.
REQ-005 SHALL have port instr_ready, output, 1: the block accepts instr_in this cycle.
REQ-006 SHALL have port stall_in, input, 1: downstream hold; freezes the whole pipeline.
REQ-007 SHALL have ports rf_addr_a and rf_addr_b, output, [0:4] each: register file read addresses, combinational copies of instr_in[11:15] and instr_in[16:20].
REQ-008 SHALL have ports rf_data_a and rf_data_b, input, [0:63] each: combinational register file read data.
REQ-009 SHALL have ports alu_rA and alu_rB, output, [0:63] each, registered: ALU operands.
REQ-010 SHALL have ports alu_Op_code [0:5], alu_R_ins [0:5] and alu_WW [0:1], output, registered: ALU control fields.
REQ-011 SHALL have port alu_result, input, [0:64-1]: combinational ALU output for the current EX contents.
REQ-012 SHALL have ports wb_en (1), wb_addr ([0:4]) and wb_data ([0:63]), output, registered: register file write port.

Function
REQ-013 SHALL implement three stages: ID (accept/operand select), EX (registered ALU inputs, valid bit ex_v, rD), WB (registered result).
REQ-014 SHALL accept an instruction when instr_valid && instr_ready; accepted word reaches the EX registers on the next edge, so ALU latency from acceptance to wb_en is 2 cycles.
REQ-015 SHALL drive instr_ready = !stall_in && !hazard_stall.
REQ-016 SHALL load a bubble into EX (ex_v=0, control fields zero) on any edge where no instruction is accepted and stall_in=0.
REQ-017 SHALL, on an edge with stall_in=1, hold EX and WB registers unchanged and keep wb_en low after that edge; it SHALL never write the same result twice.
REQ-018 SHALL set the WB stage on each non-stalled edge: wb_en <= ex_v && alu_Op_code==6'b101010 && alu_R_ins!=6'b000000; wb_addr <= EX rD; wb_data <= alu_result.
REQ-019 SHALL accept opcodes other than R_ALU (101010), including NOP 111100. These instructions SHALL pass through EX with ex_v=1 but never assert wb_en.
REQ-020 SHALL select operand sources for each of rA and rB in this priority order:
- EX forward (per REQ-026);
- WB forward: wb_en=1 and wb_addr equal to the source field, giving wb_data;
- otherwise rf_data.
REQ-021 SHALL define an EX hazard as: ex_v=1, EX opcode is R_ALU, EX R_ins!=000000, and EX rD equals instr_in rA or rB. Both fields are checked for every opcode, VNOT included.
REQ-022 SHALL treat register 0 as an ordinary register; no special-casing.
REQ-023 SHALL pass WW unchanged; width interpretation belongs to the ALU.

Reset
REQ-024 SHALL, while reset=1, asynchronously clear all of the following to 0:
- alu_rA, alu_rB, alu_Op_code, alu_R_ins, alu_WW;
- EX rD and ex_v;
- wb_en, wb_addr, wb_data.
REQ-025 SHALL discard in-flight instructions on reset assertion mid-operation. instr_ready SHALL follow REQ-015 combinationally, with hazard_stall=0 because ex_v=0.

Configuration
REQ-026 SHALL, with macro ALU_ISSUE_FWD_EN defined, resolve an EX hazard by forwarding alu_result into the ID operand mux with no stall (hazard_stall=0).
REQ-027 SHALL, without ALU_ISSUE_FWD_EN, assert hazard_stall=1 on an EX hazard. One bubble enters EX, and the instruction is accepted the following cycle via the WB forward path.

Verification
REQ-028 SHALL verify single-instruction latency: VADD WW=00, rf rA=0x0102030405060708, rB=0x0101010101010101, rD=3, ALU model attached -> wb_en=1, wb_addr=3, wb_data=0x0203040506070809 exactly 2 cycles after acceptance.
REQ-029 SHALL verify back-to-back dependency: VADD r3=r1+r2, then VXOR r4=r3^r1 -> with ALU_ISSUE_FWD_EN, accepted on consecutive cycles and the second alu_rA equals the first result; without it, instr_ready=0 for exactly 1 cycle, one bubble, and results identical.
REQ-030 SHALL verify stall: stall_in=1 for 3 cycles with an instruction in EX -> EX/WB registers frozen, instr_ready=0, exactly one wb_en pulse after release.
REQ-031 SHALL verify non-writing instructions: NOP (111100), LOAD (100000) and R_ALU with R_ins=000000 -> ex_v=1 for one cycle, no wb_en.
REQ-032 SHALL verify reset mid-operation: reset asserted asynchronously between edges with EX and WB full -> all outputs 0 immediately, no wb_en after deassertion.
REQ-033 SHALL verify WB forwarding: write r5 in WB the same cycle a new instruction reads r5 -> alu_rA equals wb_data, not the stale rf_data.
